// File: rtl/aes_seq_pkg.sv
// Shared field layout, vector type and FSM encoding for the AES vector sequencer.
package aes_seq_pkg;

    localparam int unsigned VEC_W     = 257;
    localparam int unsigned OBS_BIT   = 256;
    localparam int unsigned KEY_MSB   = 255;
    localparam int unsigned KEY_LSB   = 128;
    localparam int unsigned STATE_MSB = 127;
    localparam int unsigned STATE_LSB = 0;

    typedef struct packed {
        logic         obs;
        logic [127:0] key;
        logic [127:0] state;
    } aes_vec_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_skid_buf.sv
// Two-entry valid/ready output buffer; the producer guarantees it never pushes into a full buffer.
module seq_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic         v0, v1;
    logic [W-1:0] d0, d1;
    logic         pop;

    assign pop       = v0 && out_ready;
    assign out_valid = v0;
    assign out_data  = d0;
    assign count     = {1'b0, v0} + {1'b0, v1};

    // Entry 0 is the presented word; it only changes on a pop or when empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
        end else if (flush) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else begin
            case ({pop, in_valid})
                2'b11: begin
                    if (v1) begin
                        d0 <= d1;
                        d1 <= in_data;
                    end else begin
                        d0 <= in_data;
                    end
                end
                2'b10: begin
                    d0 <= d1;
                    v0 <= v1;
                    v1 <= 1'b0;
                end
                2'b01: begin
                    if (!v0) begin
                        d0 <= in_data;
                        v0 <= 1'b1;
                    end else begin
                        d1 <= in_data;
                        v1 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/aes_vector_sequencer.sv
// Plays a loadable vector memory out over valid/ready to the AES core.
// Build option SEQ_LOOP_EN: replay indices 0..num_vec-1 continuously until abort.
module aes_vector_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [VEC_W-1:0] ld_data,
    input  logic             start,
    input  logic [AW:0]      num_vec,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_obs,
    output logic [127:0]     out_key,
    output logic [127:0]     out_state,
    output logic [AW-1:0]    out_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BUF_W   = AW + VEC_W;
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_N   = (AW+1)'(1);

    seq_state_e       state;
    aes_vec_t         mem [DEPTH];
    aes_vec_t         wr_vec, rd_vec, buf_vec;
    logic [AW-1:0]    rd_ptr, rd_idx;
    logic             rd_valid;
    logic [AW:0]      tot, num_clamped;
    logic             issue, pop, more;
    logic [1:0]       buf_count;
    logic [2:0]       occ;
    logic [BUF_W-1:0] buf_data;
`ifndef SEQ_LOOP_EN
    logic [AW:0]      iss_cnt, xfer_cnt;
    logic             last_xfer;
`endif

    assign wr_vec = '{obs:   ld_data[OBS_BIT],
                      key:   ld_data[KEY_MSB:KEY_LSB],
                      state: ld_data[STATE_MSB:STATE_LSB]};

    assign pop = out_valid && out_ready;

    // Issue only when the word will still fit after everything already in flight lands.
    always_comb begin
        num_clamped = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
        occ         = 3'(buf_count) + 3'(rd_valid) - 3'(pop);
`ifdef SEQ_LOOP_EN
        more        = 1'b1;
`else
        more        = (iss_cnt != tot);
        last_xfer   = pop && (xfer_cnt == tot - ONE_N);
`endif
        issue       = (state == S_RUN) && !abort && more && (occ <= 3'd1);
    end

    always_ff @(posedge clk) begin
        if (ld_en && state == S_IDLE) begin
            mem[ld_addr] <= wr_vec;
        end
        if (issue) begin
            rd_vec <= mem[rd_ptr];
            rd_idx <= rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            rd_ptr   <= '0;
            tot      <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifndef SEQ_LOOP_EN
            iss_cnt  <= '0;
            xfer_cnt <= '0;
`endif
        end else begin
            rd_valid <= issue;
            busy     <= (state != S_IDLE);
            done     <= (state == S_DONE) && !abort;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tot    <= num_clamped;
                        rd_ptr <= '0;
`ifndef SEQ_LOOP_EN
                        iss_cnt  <= '0;
                        xfer_cnt <= '0;
`endif
                        state  <= (num_clamped == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
`ifdef SEQ_LOOP_EN
                        if (issue) begin
                            rd_ptr <= ({1'b0, rd_ptr} == tot - ONE_N) ? '0 : rd_ptr + AW'(1);
                        end
`else
                        if (issue) begin
                            rd_ptr  <= rd_ptr + AW'(1);
                            iss_cnt <= iss_cnt + ONE_N;
                        end
                        if (pop) begin
                            xfer_cnt <= xfer_cnt + ONE_N;
                        end
                        if (last_xfer) begin
                            state <= S_DONE;
                        end
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    seq_skid_buf #(.W(BUF_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort && state != S_IDLE),
        .in_valid  (rd_valid),
        .in_data   ({rd_idx, rd_vec}),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (buf_data),
        .count     (buf_count)
    );

    assign {out_idx, buf_vec} = buf_data;
    assign out_obs   = buf_vec.obs;
    assign out_key   = buf_vec.key;
    assign out_state = buf_vec.state;

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Self-checking bench for aes_vector_sequencer: scoreboard of expected words built from a memory model.
module tb_aes_vector_sequencer;

    logic         clk = 1'b0;
    logic         rst, ld_en, start, abort, out_ready;
    logic [3:0]   ld_addr;
    logic [256:0] ld_data;
    logic [4:0]   num_vec;
    logic         out_valid, out_obs, busy, done;
    logic [127:0] out_key, out_state;
    logic [3:0]   out_idx;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  cyc = 0;
    logic [256:0] mem_m [16];

    typedef struct {
        int unsigned num_vec;
        int unsigned mode;        // 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready
        bit          ld_mid;      // attempt a write to address 3 while running
        int unsigned abort_after; // 0 = never abort
        int unsigned exp_xfers;
    } rec_t;

    rec_t tbl [7];

    aes_vector_sequencer #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .start     (start),
        .num_vec   (num_vec),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_obs   (out_obs),
        .out_key   (out_key),
        .out_state (out_state),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [256:0] rand_word();
        return 257'({$urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic load(input int unsigned a, input logic [256:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 4'(a);
        ld_data = d;
        mem_m[a] = d;
    endtask

    task automatic play(input rec_t r);
        logic [260:0] expq [$];
        logic [260:0] cur, held, e;
        int unsigned  n, c0, xf, dn, bz, last_xc, done_cyc, abort_cyc;
        bit           stall, aborted, ended;
        n = (r.num_vec > 16) ? 16 : r.num_vec;
        for (int unsigned i = 0; i < n; i++) expq.push_back({4'(i), mem_m[i]});
        xf = 0; dn = 0; bz = 0; last_xc = 0; done_cyc = 0; abort_cyc = 0;
        stall = 1'b0; aborted = 1'b0; ended = 1'b0; held = '0;
        @(negedge clk);
        c0 = cyc;
        ld_en = 1'b0; start = 1'b1; num_vec = 5'(r.num_vec); out_ready = 1'b0;
        for (int k = 0; k < 300 && !ended; k++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; ld_en = 1'b0;
            cur = {out_idx, out_obs, out_key, out_state};
            if (stall) begin
                chk("stall_valid", 264'(out_valid), 264'(1));
                chk("stall_hold", 264'(cur), 264'(held));
            end
            if (aborted && cyc == abort_cyc + 1) chk("abort_valid", 264'(out_valid), 264'(0));
            if (done) begin
                dn++;
                done_cyc = cyc;
            end
            if (busy) bz++;
            if (dn > 0 && cyc == done_cyc + 1) chk("busy_drop", 264'(busy), 264'(0));
            if (r.ld_mid && k == 2) begin
                ld_en = 1'b1; ld_addr = 4'd3; ld_data = rand_word();
            end
            case (r.mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (r.abort_after != 0 && !aborted && xf == r.abort_after) begin
                abort = 1'b1; out_ready = 1'b0; aborted = 1'b1; abort_cyc = cyc;
            end
            stall = 1'b0;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("xfer_overrun", 264'(xf + 1), 264'(n));
                end else begin
                    e = expq.pop_front();
                    chk("xfer_data", 264'(cur), 264'(e));
                    if (r.mode == 0) chk("xfer_cycle", 264'(cyc), 264'(c0 + 3 + xf));
                end
                xf++;
                last_xc = cyc;
            end else if (out_valid && !abort) begin
                stall = 1'b1;
                held  = cur;
            end
            if ((dn > 0 && cyc >= done_cyc + 2) || (aborted && cyc >= abort_cyc + 4)) ended = 1'b1;
        end
        chk("ended", 264'(ended), 264'(1));
        chk("xfer_total", 264'(xf), 264'(r.exp_xfers));
        chk("done_count", 264'(dn), 264'(aborted ? 0 : 1));
        chk("idle_at_end", 264'(busy), 264'(0));
        if (!aborted) begin
            if (n == 0) begin
                chk("done_zero_cycle", 264'(done_cyc), 264'(c0 + 2));
                chk("busy_zero_len", 264'(bz), 264'(1));
            end else begin
                chk("done_cycle", 264'(done_cyc), 264'(last_xc + 2));
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; ld_en = 1'b0; ld_addr = '0;
        ld_data = '0; num_vec = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 264'({out_valid, out_obs, out_key, out_state, out_idx, busy, done}), 264'(0));
        rst = 1'b1;

        for (int unsigned i = 0; i < 16; i++) load(i, {1'(i % 2), 128'(i + 100), 128'(i)});

        tbl[0] = '{4,  0, 1'b0, 0, 4};
        tbl[1] = '{6,  1, 1'b0, 0, 6};
        tbl[2] = '{0,  0, 1'b0, 0, 0};
        tbl[3] = '{20, 0, 1'b1, 0, 16};
        tbl[4] = '{5,  1, 1'b0, 0, 5};
        tbl[5] = '{8,  0, 1'b0, 2, 2};
        tbl[6] = '{3,  0, 1'b0, 0, 3};

`ifdef SEQ_LOOP_EN
        play(tbl[2]);
        begin
            int unsigned lxf;
            lxf = 0;
            @(negedge clk);
            ld_en = 1'b0; start = 1'b1; num_vec = 5'd3; out_ready = 1'b1;
            for (int k = 0; k < 40 && lxf < 8; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) chk("loop_no_done", 264'(done), 264'(0));
                if (out_valid) begin
                    chk("loop_data", 264'({out_idx, out_obs, out_key, out_state}),
                        264'({4'(lxf % 3), mem_m[lxf % 3]}));
                    lxf++;
                end
            end
            chk("loop_count", 264'(lxf), 264'(8));
            abort = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            chk("loop_abort", 264'(out_valid), 264'(0));
            repeat (3) @(negedge clk);
            chk("loop_idle", 264'(busy), 264'(0));
        end
`else
        foreach (tbl[i]) play(tbl[i]);
        for (int r = 0; r < 6; r++) begin
            rec_t rr;
            int unsigned nv;
            load($urandom_range(0, 15), rand_word());
            load($urandom_range(0, 15), rand_word());
            nv = $urandom_range(0, 20);
            rr = '{nv, 2, 1'b0, 0, (nv > 16) ? 16 : nv};
            play(rr);
        end
`endif

        @(negedge clk);
        ld_en = 1'b0; start = 1'b1; num_vec = 5'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_valid", 264'(out_valid), 264'(1));
        rst = 1'b0;
        @(negedge clk);
        chk("reset_midrun", 264'({out_valid, out_obs, out_key, out_state, out_idx, busy, done}), 264'(0));
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
`ifndef SEQ_LOOP_EN
        play(tbl[0]);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
